// File: rtl/amba_axi4_stream_seda_pkg.sv
// Shared AXI4-Stream typedefs and the mat_mul stage constants.
package amba_axi4_stream_seda_pkg;

   localparam int DATA_BYTES = 4;

   typedef logic [8*DATA_BYTES-1:0] axi4s_data;
   typedef logic                    axi4s_valid;
   typedef logic                    axi4s_ready;
   typedef logic                    axi4s_last;

   localparam int MAT_DIM       = 2;
   localparam int MAT_ELEM_W    = 16;
   localparam int MAT_IN_BEATS  = 8;
   localparam int MAT_OUT_BEATS = 4;

   typedef logic [MAT_ELEM_W-1:0] mat_elem_t;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_CALC = 2'd1,
      ST_SEND = 2'd2
   } mat_state_e;

endpackage

// File: rtl/axi4s_mat_mul_2x2_core.sv
// Combinational 2x2 signed matrix product. Element order A00..A11, B00..B11;
// results C00..C11 are 32-bit and wrap on overflow.
module mat_mul_2x2_core
   import amba_axi4_stream_seda_pkg::*;
(
   input  logic [MAT_IN_BEATS-1:0][MAT_ELEM_W-1:0]   elem_i,
   output logic [MAT_OUT_BEATS-1:0][8*DATA_BYTES-1:0] res_o
);

   function automatic logic [31:0] dot2(input logic signed [15:0] x0, y0, x1, y1);
      logic signed [31:0] p0;
      logic signed [31:0] p1;
      p0 = 32'(x0) * 32'(y0);
      p1 = 32'(x1) * 32'(y1);
      return p0 + p1;
   endfunction

   assign res_o[0] = dot2(elem_i[0], elem_i[4], elem_i[1], elem_i[6]);
   assign res_o[1] = dot2(elem_i[0], elem_i[5], elem_i[1], elem_i[7]);
   assign res_o[2] = dot2(elem_i[2], elem_i[4], elem_i[3], elem_i[6]);
   assign res_o[3] = dot2(elem_i[2], elem_i[5], elem_i[3], elem_i[7]);

endmodule

// File: rtl/axi4s_mat_mul_2x2.sv
// AXI4-Stream 2x2 matrix multiply: 8 operand beats in, 4 result beats out.
// Define AXI4S_MAT_MUL_TLAST_CHECK_EN to enable the s_tlast framing check.
//
// state   | meaning
// LOAD    | accept operand beats into elem_q[in_cnt]
// CALC    | register all four products
// SEND    | present C[out_cnt] on the master port
module axi4s_mat_mul_2x2
   import amba_axi4_stream_seda_pkg::*;
(
   input  logic        ACLK,
   input  logic        ARESETn,
   input  logic [31:0] s_tdata,
   input  logic        s_tvalid,
   output logic        s_tready,
   input  logic        s_tlast,
   output logic [31:0] m_tdata,
   output logic        m_tvalid,
   input  logic        m_tready,
   output logic        m_tlast,
   output logic        frame_err
);

   mat_state_e state_q, state_d;
   logic [2:0] in_cnt_q, in_cnt_d;
   logic [1:0] out_cnt_q, out_cnt_d;
   logic [MAT_IN_BEATS-1:0][MAT_ELEM_W-1:0]   elem_q, elem_d;
   logic [MAT_OUT_BEATS-1:0][8*DATA_BYTES-1:0] c_q, c_d, c_core;
   logic        s_tready_q, s_tready_d;
   logic        m_tvalid_q, m_tvalid_d;
   logic        m_tlast_q, m_tlast_d;
   logic [31:0] m_tdata_q, m_tdata_d;
   logic        frame_err_q, frame_err_d;
   logic        s_hs, m_hs, tlast_bad;

`ifdef AXI4S_MAT_MUL_TLAST_CHECK_EN
   logic [15:0] unused_bits;
   assign unused_bits = s_tdata[31:16];
   assign tlast_bad   = s_tlast != (in_cnt_q == 3'd7);
`else
   logic [16:0] unused_bits;
   assign unused_bits = {s_tlast, s_tdata[31:16]};
   assign tlast_bad   = 1'b0;
`endif

   mat_mul_2x2_core u_core (
      .elem_i (elem_q),
      .res_o  (c_core)
   );

   assign s_hs = s_tvalid & s_tready_q;
   assign m_hs = m_tvalid_q & m_tready;

   always_comb begin
      state_d     = state_q;
      in_cnt_d    = in_cnt_q;
      out_cnt_d   = out_cnt_q;
      elem_d      = elem_q;
      c_d         = c_q;
      m_tvalid_d  = m_tvalid_q;
      m_tlast_d   = m_tlast_q;
      m_tdata_d   = m_tdata_q;
      frame_err_d = frame_err_q;
      unique case (state_q)
         ST_LOAD: begin
            if (s_hs) begin
               elem_d[in_cnt_q] = s_tdata[15:0];
               if (tlast_bad) begin
                  // Drop the partial frame; the next beat restarts at A00.
                  in_cnt_d    = 3'd0;
                  frame_err_d = 1'b1;
               end else if (in_cnt_q == 3'd7) begin
                  in_cnt_d = 3'd0;
                  state_d  = ST_CALC;
               end else begin
                  in_cnt_d = in_cnt_q + 3'd1;
               end
            end
         end
         ST_CALC: begin
            c_d        = c_core;
            out_cnt_d  = 2'd0;
            m_tdata_d  = c_core[0];
            m_tvalid_d = 1'b1;
            m_tlast_d  = 1'b0;
            state_d    = ST_SEND;
         end
         ST_SEND: begin
            if (m_hs) begin
               if (out_cnt_q == 2'd3) begin
                  m_tvalid_d = 1'b0;
                  m_tlast_d  = 1'b0;
                  state_d    = ST_LOAD;
               end else begin
                  out_cnt_d = out_cnt_q + 2'd1;
                  m_tdata_d = c_q[out_cnt_q + 2'd1];
                  m_tlast_d = (out_cnt_q == 2'd2);
               end
            end
         end
         default: state_d = ST_LOAD;
      endcase
      s_tready_d = (state_d == ST_LOAD);
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state_q     <= ST_LOAD;
         in_cnt_q    <= 3'd0;
         out_cnt_q   <= 2'd0;
         elem_q      <= '0;
         c_q         <= '0;
         s_tready_q  <= 1'b0;
         m_tvalid_q  <= 1'b0;
         m_tlast_q   <= 1'b0;
         m_tdata_q   <= '0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_cnt_q    <= in_cnt_d;
         out_cnt_q   <= out_cnt_d;
         elem_q      <= elem_d;
         c_q         <= c_d;
         s_tready_q  <= s_tready_d;
         m_tvalid_q  <= m_tvalid_d;
         m_tlast_q   <= m_tlast_d;
         m_tdata_q   <= m_tdata_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign s_tready  = s_tready_q;
   assign m_tvalid  = m_tvalid_q;
   assign m_tlast   = m_tlast_q;
   assign m_tdata   = m_tdata_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_axi4s_mat_mul_2x2.sv
// Self-checking bench for axi4s_mat_mul_2x2: table vectors, hand-written
// corner sequences and random frames scored against an arithmetic model.
module tb_axi4s_mat_mul_2x2;

   typedef logic [7:0][15:0] elems_t;
   typedef logic [3:0][31:0] res_t;
   typedef struct {
      elems_t e;
      res_t   c;
   } vec_t;

   logic        ACLK = 1'b0;
   logic        ARESETn = 1'b0;
   logic [31:0] s_tdata = '0;
   logic        s_tvalid = 1'b0;
   logic        s_tready;
   logic        s_tlast = 1'b0;
   logic [31:0] m_tdata;
   logic        m_tvalid;
   logic        m_tready = 1'b0;
   logic        m_tlast;
   logic        frame_err;

   axi4s_mat_mul_2x2 dut (
      .ACLK      (ACLK),
      .ARESETn   (ARESETn),
      .s_tdata   (s_tdata),
      .s_tvalid  (s_tvalid),
      .s_tready  (s_tready),
      .s_tlast   (s_tlast),
      .m_tdata   (m_tdata),
      .m_tvalid  (m_tvalid),
      .m_tready  (m_tready),
      .m_tlast   (m_tlast),
      .frame_err (frame_err)
   );

   always #5 ACLK = ~ACLK;

   int          pass_cnt = 0;
   int          total_cnt = 0;
   int          cyc = 0;
   int          a00_edge = 0;
   int          c11_edge = -100;
   logic [31:0] exp_q[$];
   bit          rand_rdy = 1'b0;

   always @(posedge ACLK) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
      else pass_cnt++;
   endtask

   // Reference: C = A*B with plain integer arithmetic, low 32 bits kept.
   function automatic res_t model(input elems_t e);
      longint a[2][2];
      longint b[2][2];
      longint s;
      res_t   r;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) begin
            a[i][j] = longint'($signed(e[i*2+j]));
            b[i][j] = longint'($signed(e[4+i*2+j]));
         end
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) begin
            s = a[i][0] * b[0][j] + a[i][1] * b[1][j];
            r[i*2+j] = s[31:0];
         end
      return r;
   endfunction

   function automatic vec_t mk(input int a00, a01, a10, a11, b00, b01, b10, b11,
                               input logic [31:0] c00, c01, c10, c11);
      vec_t v;
      v.e[0] = 16'(a00); v.e[1] = 16'(a01); v.e[2] = 16'(a10); v.e[3] = 16'(a11);
      v.e[4] = 16'(b00); v.e[5] = 16'(b01); v.e[6] = 16'(b10); v.e[7] = 16'(b11);
      v.c[0] = c00; v.c[1] = c01; v.c[2] = c10; v.c[3] = c11;
      return v;
   endfunction

   task automatic push_exp(input res_t r);
      for (int k = 0; k < 4; k++) exp_q.push_back(r[k]);
   endtask

   // Output monitor: scoreboard compare on each accepted beat, stability under stall.
   int          beat_idx = 0;
   bit          stall_prev = 1'b0;
   logic [31:0] prev_data;
   logic        prev_last;
   always @(negedge ACLK) begin
      if (!ARESETn) begin
         beat_idx   = 0;
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("stall_valid", {31'd0, m_tvalid}, 32'd1);
            check("stall_data", m_tdata, prev_data);
            check("stall_last", {31'd0, m_tlast}, {31'd0, prev_last});
         end
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", m_tdata, 32'hxxxx_xxxx);
            end else begin
               check("m_tdata", m_tdata, exp_q.pop_front());
               check("m_tlast", {31'd0, m_tlast}, {31'd0, beat_idx == 3});
               if (beat_idx == 3) c11_edge = cyc + 1;
               beat_idx = (beat_idx + 1) % 4;
            end
         end
         stall_prev = m_tvalid && !m_tready;
         prev_data  = m_tdata;
         prev_last  = m_tlast;
      end
   end

   initial begin
      forever begin
         @(posedge ACLK);
         #1;
         if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
      end
   end

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   // Sends beats 0..n_beats-1; tlast on beat 7 and on beat bad_at.
   task automatic send_frame(input elems_t e, input int n_beats, input int bad_at,
                             input bit gaps, input bit keep_valid);
      int w;
      for (int i = 0; i < n_beats; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            s_tvalid = 1'b0;
            tick();
         end
         s_tvalid = 1'b1;
         s_tdata  = {16'($urandom), e[i]};
         s_tlast  = (i == 7) || (i == bad_at);
         w = 0;
         while (!s_tready && w < 100) begin
            tick();
            w++;
         end
         if (!s_tready) begin
            check("s_tready_timeout", {31'd0, s_tready}, 32'd1);
            s_tvalid = 1'b0;
            return;
         end
         if (i == 0) a00_edge = cyc + 1;
         tick();
      end
      if (!keep_valid) s_tvalid = 1'b0;
      s_tlast = 1'b0;
   endtask

   task automatic drain();
      int w = 0;
      while (exp_q.size() != 0 && w < 400) begin
         tick();
         w++;
      end
      if (exp_q.size() != 0) begin
         check("drain_timeout", exp_q.size(), 32'd0);
         exp_q.delete();
      end
      repeat (2) tick();
   endtask

   vec_t   tbl[6];
   elems_t re;
   int     w;

   initial begin
      tbl[0] = mk(1, 2, 3, 4, 1, 0, 0, 1, 32'd1, 32'd2, 32'd3, 32'd4);
      tbl[1] = mk(-32768, -32768, 0, 0, -32768, 0, -32768, 0,
                  32'h8000_0000, 32'd0, 32'd0, 32'd0);
      tbl[2] = mk(1, 2, 3, 4, 5, 6, 7, 8, 32'd19, 32'd22, 32'd43, 32'd50);
      tbl[3] = mk(-1, 0, 0, -1, 7, -3, 2, 5,
                  32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFE, 32'hFFFF_FFFB);
      tbl[4] = mk(32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767,
                  32'h7FFE_0002, 32'h7FFE_0002, 32'h7FFE_0002, 32'h7FFE_0002);
      tbl[5] = mk(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768,
                  32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);

      // Reset held with s_tvalid high
      s_tvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_s_tready", {31'd0, s_tready}, 32'd0);
         check("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
         check("rst_m_tdata", m_tdata, 32'd0);
         check("rst_frame_err", {31'd0, frame_err}, 32'd0);
      end
      ARESETn = 1'b1;
      tick();
      check("rel_s_tready", {31'd0, s_tready}, 32'd1);
      s_tvalid = 1'b0;
      tick();

      // Table vectors with latency checks, m_tready high
      m_tready = 1'b1;
      for (int t = 0; t < 6; t++) begin
         push_exp(tbl[t].c);
         send_frame(tbl[t].e, 8, -1, 1'b0, 1'b0);
         check("calc_m_tvalid", {31'd0, m_tvalid}, 32'd0);
         check("calc_s_tready", {31'd0, s_tready}, 32'd0);
         tick();
         check("lat_m_tvalid", {31'd0, m_tvalid}, 32'd1);
         check("lat_c00", m_tdata, tbl[t].c[0]);
         drain();
      end

      // Backpressure at C01 for 20 cycles
      m_tready = 1'b0;
      push_exp(tbl[2].c);
      send_frame(tbl[2].e, 8, -1, 1'b0, 1'b0);
      w = 0;
      while (!m_tvalid && w < 20) begin
         tick();
         w++;
      end
      check("bp_first_valid", {31'd0, m_tvalid}, 32'd1);
      m_tready = 1'b1;
      tick();
      m_tready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("bp_valid", {31'd0, m_tvalid}, 32'd1);
         check("bp_c01", m_tdata, 32'd22);
         check("bp_last", {31'd0, m_tlast}, 32'd0);
         check("bp_s_tready", {31'd0, s_tready}, 32'd0);
      end
      m_tready = 1'b1;
      drain();

      // Back-to-back frames, s_tvalid held high
      push_exp(tbl[2].c);
      send_frame(tbl[2].e, 8, -1, 1'b0, 1'b1);
      push_exp(tbl[3].c);
      send_frame(tbl[3].e, 8, -1, 1'b0, 1'b0);
      check("b2b_a00_edge", a00_edge, c11_edge + 1);
      drain();

      // Reset mid-frame: partial operands are discarded
      send_frame(tbl[2].e, 4, -1, 1'b0, 1'b0);
      ARESETn = 1'b0;
      repeat (2) tick();
      check("midrst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
      ARESETn = 1'b1;
      tick();
      push_exp(tbl[0].c);
      send_frame(tbl[0].e, 8, -1, 1'b0, 1'b0);
      drain();

`ifdef AXI4S_MAT_MUL_TLAST_CHECK_EN
      // Early tlast on beat 5 drops the frame and latches frame_err
      check("ferr_before", {31'd0, frame_err}, 32'd0);
      send_frame(tbl[4].e, 5, 4, 1'b0, 1'b0);
      check("ferr_set", {31'd0, frame_err}, 32'd1);
      check("ferr_s_tready", {31'd0, s_tready}, 32'd1);
      repeat (12) tick();
      check("ferr_no_output", {31'd0, m_tvalid}, 32'd0);
      push_exp(tbl[2].c);
      send_frame(tbl[2].e, 8, -1, 1'b0, 1'b0);
      drain();
      check("ferr_sticky", {31'd0, frame_err}, 32'd1);
`endif

      // Random frames with random gaps and random m_tready
      rand_rdy = 1'b1;
      for (int f = 0; f < 12; f++) begin
         for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 3))
               0:       re[k] = 16'h8000;
               1:       re[k] = 16'h7FFF;
               default: re[k] = 16'($urandom);
            endcase
         end
         push_exp(model(re));
         send_frame(re, 8, -1, 1'b1, 1'b0);
      end
      drain();
      rand_rdy = 1'b0;
      m_tready = 1'b1;
`ifndef AXI4S_MAT_MUL_TLAST_CHECK_EN
      check("ferr_tied_low", {31'd0, frame_err}, 32'd0);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/axi4s_mat_mul_2x2.md
# axi4s_mat_mul_2x2

Stream compute stage for the mat_mul example. It consumes two 2x2 signed operand matrices A and B as one 8-beat AXI4-Stream frame and computes C = A·B. It then emits C as one 4-beat AXI4-Stream frame. Its master port is the source that the formal VIP monitors in source mode, with a 4-byte data bus and no TID, TDEST or TUSER.

## Interface
- DATA_BYTES, 4, TDATA width in bytes; fixed at 4, taken from the shared package.
- ELEM_W, 16, operand element width; signed, carried in TDATA[15:0].
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESETn  in  1  reset; synchronous and active-low.
- s_tdata  in  32  operand beat; bits [31:16] are ignored.
- s_tvalid  in  1  operand beat valid.
- s_tready  out  1  operand beat accepted.
- s_tlast  in  1  marks the last beat of the operand frame.
- m_tdata  out  32  result element, two's complement.
- m_tvalid  out  1  result beat valid.
- m_tready  in  1  downstream accepts the result beat.
- m_tlast  out  1  marks the last result beat, C11.
- frame_err  out  1  sticky framing error; reads 0 when the check is compiled out.

## Operation
- Input beat order: A00, A01, A10, A11, B00, B01, B10, B11 (row-major).
- Output beat order: C00, C01, C10, C11.
- Cij = Ai0·B0j + Ai1·B1j.
- Arithmetic: 16x16 signed products; the 33-bit sum is truncated to 32 bits and wraps.
- FSM states:
  - LOAD: s_tready=1. Each handshake writes element register [in_cnt] and increments in_cnt (3 bits). When in_cnt=7 and a handshake occurs, go to CALC.
  - CALC: s_tready=0. All four Cij are registered in one cycle. out_cnt=0. Go to SEND.
  - SEND: m_tvalid=1, m_tdata=C[out_cnt], m_tlast=(out_cnt==3). On a handshake out_cnt increments. A handshake at out_cnt=3 goes to LOAD with in_cnt=0.
- Reset values: state=LOAD, in_cnt=0, out_cnt=0, m_tvalid=0, m_tlast=0, m_tdata=0, frame_err=0. s_tready=0 while ARESETn=0 and 1 in the first cycle after reset release.
- Reset mid-frame: partial operands and results are discarded. No output beat is produced for the aborted frame.
- No input is accepted in CALC or SEND; there is no overlap between frames.

## Timing
- All outputs are registered and there is no combinational path from input to output.
- Latency: the 8th input handshake at edge N gives state CALC after N, state SEND and m_tvalid=1 after N+1. C00 is therefore presented one cycle after CALC.
- Minimum frame period is 8 + 1 + 4 = 13 cycles with m_tready held high.
- Once m_tvalid rises it holds until the handshake. m_tdata and m_tlast stay stable while m_tvalid=1 and m_tready=0.
- m_tvalid does not depend on m_tready. s_tready does not depend on s_tvalid.
- m_tready has no maximum wait; stalls of any length are legal. The VIP MAXWAITS=16 limit bounds the bench, not this block.

## Configuration
- AXI4S_MAT_MUL_TLAST_CHECK_EN defined:
  - A framing error is s_tlast=1 on a beat with in_cnt≠7, or s_tlast=0 on the beat with in_cnt=7.
  - On the offending handshake frame_err is set and stays set until reset, in_cnt clears to 0, the state stays LOAD, and the frame is dropped with no output.
  - The next beat is treated as A00.
- Macro undefined: s_tlast is ignored, the frame boundary comes from in_cnt alone, and frame_err is tied to 0.

## Structure
- amba_axi4_stream_seda_pkg provides the axi4s_data, axi4s_valid, axi4s_ready and axi4s_last typedefs.
- The same package gains MAT_DIM=2, MAT_ELEM_W=16, MAT_IN_BEATS=8 and MAT_OUT_BEATS=4.
- One sub-module, mat_mul_2x2_core, is combinational: it takes 8 elements and produces 4 32-bit results. The top module owns the FSM, counters and registers.

## Test plan
- Reset: hold ARESETn=0 for 3 cycles with s_tvalid=1. Required: s_tready=0, m_tvalid=0, m_tdata=0 and frame_err=0 throughout, and s_tready=1 in the first cycle after release.
- Identity: A=[1,2;3,4], B=[1,0;0,1], m_tready=1. Required: outputs 1,2,3,4, m_tlast only on the 4th beat, and C00 valid 2 cycles after the 8th handshake.
- Wrap: A=[-32768,-32768;0,0], B=[-32768,0;-32768,0]. Required: C00=0x80000000, then C01=0, C10=0, C11=0.
- Backpressure: hold m_tready=0 for 20 cycles at C01. Required: m_tvalid, m_tdata and m_tlast hold stable, s_tready=0, and the frame completes normally when m_tready rises.
- Back-to-back: two frames with s_tvalid held high. Required: the second frame's A00 is accepted in the cycle after C11 is accepted, and both result sets are correct.
- Framing error (AXI4S_MAT_MUL_TLAST_CHECK_EN defined): assert s_tlast on beat 5, then send a valid 8-beat frame. Required: frame_err=1 from the cycle after beat 5, no output for the bad frame, and correct output for the good frame.
